// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: bit-engine state encoding and default slot timing
// (in clk cycles at 1 MHz). Used by both the slave responder and the master driver.
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SLOT       = 3'd1,
    ST_RST_LOW    = 3'd2,
    ST_PRES_WAIT  = 3'd3,
    ST_PRES_DRIVE = 3'd4,
    ST_RECOVER    = 3'd5
  } ow_state_e;

  localparam int unsigned OW_RST_MIN   = 400;
  localparam int unsigned OW_PRES_WAIT = 30;
  localparam int unsigned OW_PRES_LEN  = 120;
  localparam int unsigned OW_SAMPLE_AT = 30;
  localparam int unsigned OW_HOLD_LEN  = 45;

  function automatic int unsigned ow_cnt_width(input int unsigned rst_min,
                                               input int unsigned pres_len);
    return $clog2(((rst_min > pres_len) ? rst_min : pres_len) + 1);
  endfunction

endpackage

// File: rtl/onewire_bus_sync.sv
// Two-flop synchroniser for the open-drain bus plus single-cycle fall/rise pulses
// derived from the synchronised level.
module onewire_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic bus_i,
  output logic bus_s_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to low so a bus already held low at reset release never looks like a fresh fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= bus_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign bus_s_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;
  assign rise_o  = ~prev_q & sync_q;

endmodule

// File: rtl/onewire_slave_responder.sv
// 1-Wire slave bit engine: detects master resets, answers with presence, samples
// write slots and pulls the bus low to return a 0 on read slots.
//   state      | meaning
//   IDLE       | bus idle, waiting for a master fall
//   SLOT       | timing a master slot (sample / hold / reset detect)
//   RST_LOW    | reset pulse detected, waiting for the master to release
//   PRES_WAIT  | gap between reset release and presence drive
//   PRES_DRIVE | driving the presence pulse
//   RECOVER    | presence released, waiting for the bus to float high
module onewire_slave_responder
  import onewire_pkg::*;
#(
  parameter int unsigned RST_MIN   = OW_RST_MIN,
  parameter int unsigned PRES_WAIT = OW_PRES_WAIT,
  parameter int unsigned PRES_LEN  = OW_PRES_LEN,
  parameter int unsigned SAMPLE_AT = OW_SAMPLE_AT,
  parameter int unsigned HOLD_LEN  = OW_HOLD_LEN
) (
  input  logic clk,
  input  logic reset,
  inout  wire  bus,
  input  logic i_tx_en,
  input  logic i_tx_bit,
  output logic o_rx_bit,
  output logic o_rx_valid,
  output logic o_tx_ack,
  output logic o_reset_det,
  output logic o_pres_done,
  output logic o_busy
);

  localparam int unsigned CW = ow_cnt_width(RST_MIN, PRES_LEN);

  localparam logic [CW-1:0] C_SAT      = CW'(RST_MIN);
  localparam logic [CW-1:0] C_RST_TRIG = CW'(RST_MIN - 1);
  localparam logic [CW-1:0] C_SAMPLE   = CW'(SAMPLE_AT);
  localparam logic [CW-1:0] C_HOLD     = CW'(HOLD_LEN);
  localparam logic [CW-1:0] C_PW_END   = CW'(PRES_WAIT - 1);
  localparam logic [CW-1:0] C_PL_END   = CW'(PRES_LEN - 1);

  ow_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          bus_oe_q;
  logic          tx_en_q;
  logic          tx_bit_q;
  logic          rx_q;
  logic          rx_bit_q;
  logic          rx_valid_q;
  logic          tx_ack_q;
  logic          reset_det_q;
  logic          pres_done_q;

  logic bus_s;
  logic fall;
  logic rise;

  onewire_bus_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .bus_i   (bus),
    .bus_s_o (bus_s),
    .fall_o  (fall),
    .rise_o  (rise)
  );

  assign cnt_d = (cnt_q == C_SAT) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_oe_q    <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_bit_q    <= 1'b0;
      rx_q        <= 1'b0;
      rx_bit_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      reset_det_q <= 1'b0;
      pres_done_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      reset_det_q <= 1'b0;
      pres_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q  <= ST_SLOT;
            cnt_q    <= '0;
            tx_en_q  <= i_tx_en;
            tx_bit_q <= i_tx_bit;
            bus_oe_q <= i_tx_en & ~i_tx_bit;
          end
        end
        ST_SLOT: begin
          cnt_q    <= cnt_d;
          bus_oe_q <= tx_en_q & ~tx_bit_q & (cnt_d < C_HOLD);
          if (cnt_d == C_SAMPLE) rx_q <= bus_s;
          if (bus_s && (cnt_q > C_SAMPLE)) begin
            rx_valid_q <= 1'b1;
            rx_bit_q   <= rx_q;
            tx_ack_q   <= tx_en_q;
            bus_oe_q   <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (!bus_s && (cnt_d == C_RST_TRIG)) begin
            // The fall cycle itself is the first low cycle, so this marks RST_MIN lows.
            bus_oe_q <= 1'b0;
            state_q  <= ST_RST_LOW;
          end
        end
        ST_RST_LOW: begin
          cnt_q <= cnt_d;
          if (rise) begin
            reset_det_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_PRES_WAIT;
          end
        end
        ST_PRES_WAIT: begin
          if (cnt_q == C_PW_END) begin
            cnt_q    <= '0;
            bus_oe_q <= 1'b1;
            state_q  <= ST_PRES_DRIVE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_PRES_DRIVE: begin
          if (cnt_q == C_PL_END) begin
            cnt_q    <= '0;
            bus_oe_q <= 1'b0;
            state_q  <= ST_RECOVER;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RECOVER: begin
          if (bus_s) begin
            pres_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          bus_oe_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus = bus_oe_q ? 1'b0 : 1'bz;

  assign o_rx_bit    = rx_bit_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_tx_ack    = tx_ack_q;
  assign o_reset_det = reset_det_q;
  assign o_pres_done = pres_done_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule
